// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALUOp (also used by
// ALU_Ctrl), FSM states, mux selects and the decoded control vector.
package cpu_ctrl_pkg;

    localparam int unsigned AluOpW = 3;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSltiu = 6'b001011;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [2:0] {
        AluRType = 3'd0,
        AluAddi  = 3'd1,
        AluSltiu = 3'd2,
        AluBeq   = 3'd3,
        AluLui   = 3'd4,
        AluOri   = 3'd5,
        AluBne   = 3'd6
    } alu_op_e;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExec   = 4'd2,
        StWb     = 4'd3,
        StAddr   = 4'd4,
        StMemRd  = 4'd5,
        StMemWb  = 4'd6,
        StMemWr  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StHalt   = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        PcSrcAlu    = 2'd0,
        PcSrcAluOut = 2'd1,
        PcSrcJump   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        SrcBRt    = 2'd0,
        SrcBFour  = 2'd1,
        SrcBBrOff = 2'd2,
        SrcBImm   = 2'd3
    } alu_src_b_e;

    typedef struct packed {
        logic       pc_we;
        pc_src_e    pc_src;
        logic       ir_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
    } ctrl_t;

    function automatic alu_op_e itype_alu_op(input logic [5:0] op);
        case (op)
            OpSltiu: return AluSltiu;
            OpLui:   return AluLui;
            OpOri:   return AluOri;
            default: return AluAddi;
        endcase
    endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Moore control-vector decode for the multi-cycle controller: state plus latched opcode,
// with zero/mem_ready only gating the PC and IR write enables.
module mc_out_dec
    import cpu_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_rd    = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluAddi;
                ctrl_o.ir_we     = mem_ready_i;
                ctrl_o.pc_we     = mem_ready_i;
            end
            // Branch target is computed speculatively into ALUOut.
            StDecode: begin
                ctrl_o.alu_src_b = SrcBBrOff;
                ctrl_o.alu_op    = AluAddi;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                if (op_i == OpRType) begin
                    ctrl_o.alu_src_b = SrcBRt;
                    ctrl_o.alu_op    = AluRType;
                end else begin
                    ctrl_o.alu_src_b = SrcBImm;
                    ctrl_o.alu_op    = itype_alu_op(op_i);
                end
            end
            StWb: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = (op_i == OpRType);
            end
            StAddr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAddi;
            end
            StMemRd: begin
                ctrl_o.mem_rd = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            StMemWb: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_wr = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBRt;
                ctrl_o.pc_src    = PcSrcAluOut;
                if (op_i == OpBne) begin
                    ctrl_o.alu_op = AluBne;
                    ctrl_o.pc_we  = ~zero_i;
                end else begin
                    ctrl_o.alu_op = AluBeq;
                    ctrl_o.pc_we  = zero_i;
                end
            end
            StJump: begin
                ctrl_o.pc_we  = 1'b1;
                ctrl_o.pc_src = PcSrcJump;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU with memory-wait timeout.
// Define MC_ILLEGAL_TRAP_EN to halt on unknown opcodes instead of treating them as NOPs.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned ALUOP_W = AluOpW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_we_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_we_o,
    output logic               iord_o,
    output logic               mem_rd_o,
    output logic               mem_wr_o,
    output logic               reg_we_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               bus_err_o,
    output logic               illegal_o,
    output logic [3:0]         state_o
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic [5:0]      op_q;
    logic            wait_state;
    logic            timeout_hit;
    ctrl_t           ctrl;

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    assign wait_state  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            StFetch:  if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode_i)
                    OpRType, OpAddi, OpSltiu, OpLui, OpOri: state_d = StExec;
                    OpLw, OpSw:                             state_d = StAddr;
                    OpBeq, OpBne:                           state_d = StBranch;
                    OpJ:                                    state_d = StJump;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d   = StHalt;
                        illegal_d = 1'b1;
`else
                        state_d   = StFetch;
`endif
                    end
                endcase
            end
            StExec:   state_d = StWb;
            StWb:     state_d = StFetch;
            StAddr:   state_d = (op_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready_i) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready_i) state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase

        // A completing handshake always beats the timeout in the same cycle.
        if (wait_state && !mem_ready_i) begin
            if (timeout_hit) begin
                state_d   = StHalt;
                bus_err_d = 1'b1;
            end
            if (cnt_q != {CntW{1'b1}}) cnt_d = cnt_q + 1'b1;
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            if (state_q == StDecode) op_q <= opcode_i;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    mc_out_dec u_out_dec (
        .state_i     (state_q),
        .op_i        (op_q),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    assign pc_we_o      = ctrl.pc_we;
    assign pc_src_o     = ctrl.pc_src;
    assign ir_we_o      = ctrl.ir_we;
    assign iord_o       = ctrl.iord;
    assign mem_rd_o     = ctrl.mem_rd;
    assign mem_wr_o     = ctrl.mem_wr;
    assign reg_we_o     = ctrl.reg_we;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign ALUOp_o      = ALUOP_W'(ctrl.alu_op);
    assign bus_err_o    = bus_err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl; follows MC_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_multi_cycle_ctrl;

    localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SExec = 4'd2, SWb = 4'd3;
    localparam logic [3:0] SAddr = 4'd4, SMemRd = 4'd5, SMemWb = 4'd6, SMemWr = 4'd7;
    localparam logic [3:0] SBranch = 4'd8, SJump = 4'd9, SHalt = 4'd10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       ready;
    logic       pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic       bus_err, illegal;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.TIMEOUT(15), .ALUOP_W(3)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .mem_ready_i  (ready),
        .pc_we_o      (pc_we),
        .pc_src_o     (pc_src),
        .ir_we_o      (ir_we),
        .iord_o       (iord),
        .mem_rd_o     (mem_rd),
        .mem_wr_o     (mem_wr),
        .reg_we_o     (reg_we),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .ALUOp_o      (alu_op),
        .bus_err_o    (bus_err),
        .illegal_o    (illegal),
        .state_o      (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ready  = 1'b1;
        zero   = 1'b0;
        opcode = 6'b000000;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_state", state, SFetch);
        check("rst_bus_err", bus_err, 0);
        check("rst_illegal", illegal, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_reg_we", reg_we, 0);

        // add: FETCH, DECODE, EXEC, WB
        check("fetch_mem_rd", mem_rd, 1);
        check("fetch_ir_we", ir_we, 1);
        check("fetch_pc_we", pc_we, 1);
        check("fetch_aluop", alu_op, 1);
        check("fetch_src_b", alu_src_b, 1);
        check("fetch_iord", iord, 0);
        tick();
        check("add_decode", state, SDecode);
        check("decode_src_b", alu_src_b, 2);
        check("decode_aluop", alu_op, 1);
        check("decode_reg_we", reg_we, 0);
        tick();
        check("add_exec", state, SExec);
        check("exec_aluop", alu_op, 0);
        check("exec_src_a", alu_src_a, 1);
        check("exec_src_b", alu_src_b, 0);
        check("exec_reg_we", reg_we, 0);
        tick();
        check("add_wb", state, SWb);
        check("wb_reg_we", reg_we, 1);
        check("wb_reg_dst", reg_dst, 1);
        check("wb_mem_to_reg", mem_to_reg, 0);
        tick();
        check("add_back", state, SFetch);

        // lw with three wait cycles in MEMRD
        opcode = 6'b100011;
        tick();
        tick();
        check("lw_addr", state, SAddr);
        check("addr_src_b", alu_src_b, 3);
        check("addr_aluop", alu_op, 1);
        tick();
        ready = 1'b0;
        #1;
        check("lw_memrd", state, SMemRd);
        check("memrd_rd", mem_rd, 1);
        check("memrd_iord", iord, 1);
        tick();
        tick();
        check("lw_wait", state, SMemRd);
        tick();
        ready = 1'b1;
        #1;
        check("lw_last_wait", state, SMemRd);
        tick();
        check("lw_memwb", state, SMemWb);
        check("memwb_m2r", mem_to_reg, 1);
        check("memwb_reg_we", reg_we, 1);
        check("memwb_reg_dst", reg_dst, 0);
        check("lw_bus_err", bus_err, 0);
        tick();
        check("lw_back", state, SFetch);

        // sw, then reset while in MEMWR
        opcode = 6'b101011;
        tick();
        tick();
        tick();
        check("sw_memwr", state, SMemWr);
        check("memwr_wr", mem_wr, 1);
        check("memwr_iord", iord, 1);
        ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        #1;
        check("rst_mid_state", state, SFetch);
        check("rst_mid_mem_wr", mem_wr, 0);

        // beq taken
        opcode = 6'b000100;
        tick();
        tick();
        zero = 1'b1;
        #1;
        check("beq_state", state, SBranch);
        check("beq_pc_we", pc_we, 1);
        check("beq_pc_src", pc_src, 1);
        check("beq_aluop", alu_op, 3);
        tick();
        check("beq_back", state, SFetch);

        // bne with zero set is not taken
        opcode = 6'b000101;
        tick();
        tick();
        #1;
        check("bne_pc_we_z1", pc_we, 0);
        check("bne_aluop", alu_op, 6);
        zero = 1'b0;
        #1;
        check("bne_pc_we_z0", pc_we, 1);
        tick();
        check("bne_back", state, SFetch);

        // j
        opcode = 6'b000010;
        tick();
        tick();
        check("j_state", state, SJump);
        check("j_pc_we", pc_we, 1);
        check("j_pc_src", pc_src, 2);
        tick();
        check("j_back", state, SFetch);

        // ori
        opcode = 6'b001101;
        tick();
        tick();
        check("ori_exec", state, SExec);
        check("ori_aluop", alu_op, 5);
        check("ori_src_b", alu_src_b, 3);
        tick();
        check("ori_reg_dst", reg_dst, 0);
        check("ori_reg_we", reg_we, 1);
        tick();

        // unknown opcode
        opcode = 6'b111111;
        tick();
        check("ill_decode_rd", mem_rd, 0);
        check("ill_decode_wr", mem_wr, 0);
        check("ill_decode_we", reg_we, 0);
        check("ill_decode_pc", pc_we, 0);
        tick();
`ifdef MC_ILLEGAL_TRAP_EN
        check("ill_state", state, SHalt);
        check("ill_flag", illegal, 1);
        tick();
        check("ill_sticky", state, SHalt);
`else
        check("ill_state", state, SFetch);
        check("ill_flag", illegal, 0);
`endif
        opcode = 6'b000000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("ill_rst_state", state, SFetch);
        check("ill_rst_flag", illegal, 0);

        // handshake on the 15th wait cycle beats the timeout
        ready = 1'b0;
        repeat (14) tick();
        ready = 1'b1;
        #1;
        check("hs_still_fetch", state, SFetch);
        check("hs_pc_we", pc_we, 1);
        tick();
        check("hs_decode", state, SDecode);
        check("hs_bus_err", bus_err, 0);

        // timeout: 15 wait cycles in FETCH -> HALT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ready = 1'b0;
        repeat (14) tick();
        check("to_pre_state", state, SFetch);
        check("to_pre_err", bus_err, 0);
        tick();
        check("to_state", state, SHalt);
        check("to_bus_err", bus_err, 1);
        check("halt_mem_rd", mem_rd, 0);
        ready = 1'b1;
        tick();
        check("halt_stays", state, SHalt);
        check("halt_pc_we", pc_we, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("to_rst_state", state, SFetch);
        check("to_rst_err", bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS-subset CPU.
- Sequences the shared datapath per instruction (PC, IR, register file, data memory, single ALU) through fetch/decode/execute/memory/writeback.
- Drives the 3-bit ALUOp consumed by ALU_Ctrl, so the one ALU serves PC increment, branch-target add, compare and execute.
- Waits on a memory-ready handshake; times out if memory never responds.

Parameters:
- TIMEOUT, 15, max cycles spent waiting on mem_ready_i in one memory state before bus_err_o; 0 disables the timeout.
- ALUOP_W, 3, ALUOp width; must match ALU_Ctrl.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- opcode_i  in  6  IR[31:26], valid from DECODE onward
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current access this cycle
- pc_we_o  out  1  PC write enable
- pc_src_o  out  2  PC source: 0 ALU result, 1 ALUOut (branch target), 2 jump target
- ir_we_o  out  1  IR load
- iord_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_rd_o  out  1  memory read strobe
- mem_wr_o  out  1  memory write strobe
- reg_we_o  out  1  register-file write
- reg_dst_o  out  1  destination: 1 rd, 0 rt
- mem_to_reg_o  out  1  writeback source: 1 MDR, 0 ALUOut
- alu_src_a_o  out  1  ALU A: 0 PC, 1 rs
- alu_src_b_o  out  2  ALU B: 0 rt, 1 constant 4, 2 sign-ext imm<<2, 3 extended imm
- ALUOp_o  out  3  R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6
- bus_err_o  out  1  sticky memory timeout
- illegal_o  out  1  unknown opcode (see Optional Feature)
- state_o  out  4  current state, for debug

Behaviour:
- State register only. Outputs are a Moore decode of state plus the latched opcode. zero_i and mem_ready_i qualify pc_we_o and the next state only.
- Reset (rst_i=0 at a clk_i edge): state=FETCH, wait counter=0, bus_err_o=0, illegal_o=0. A reset mid-instruction aborts it, and no write strobe is asserted in the cycle after reset.
- All strobes default to 0. pc_src_o, alu_src_*_o, reg_dst_o, mem_to_reg_o and ALUOp_o default to 0.
- FETCH:
  - mem_rd=1, iord=0, alu_src_a=0, alu_src_b=1, ALUOp=ADDI.
  - ir_we and pc_we (pc_src=0) assert only in the cycle mem_ready_i=1; then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=2, ALUOp=ADDI (branch target into ALUOut). Next state by opcode:
  - R-type 000000, addi 001000, sltiu 001011, lui 001111, ori 001101 -> EXEC.
  - lw 100011, sw 101011 -> ADDR.
  - beq 000100, bne 000101 -> BRANCH.
  - j 000010 -> JUMP.
  - any other opcode -> illegal handling.
- EXEC: alu_src_a=1. R-type: alu_src_b=0, ALUOp=R_TYPE. I-type: alu_src_b=3 with ALUOp ADDI/SLTIU/LUI/ORI. Next state WB.
- WB: reg_we=1; reg_dst=1 for R-type, else 0; mem_to_reg=0. Next state FETCH.
- ADDR: alu_src_a=1, alu_src_b=3, ALUOp=ADDI. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_rd=1, iord=1. Hold until mem_ready_i=1, then go to MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: mem_wr=1, iord=1. Hold until mem_ready_i=1, then go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, ALUOp=BEQ or BNE, pc_src=1. pc_we = zero_i for beq, ~zero_i for bne. Next state FETCH.
- JUMP: pc_we=1, pc_src=2. Next state FETCH.
- Cycle counts with zero wait: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3.
- Wait counter:
  - Cleared on entering FETCH, MEMRD or MEMWR; increments each cycle mem_ready_i=0 in those states; saturates.
  - When TIMEOUT!=0 and count reaches TIMEOUT: set bus_err_o, go to HALT.
  - mem_ready_i=1 in the same cycle as the timeout: the handshake wins.
- HALT: all strobes 0. Only reset leaves HALT.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: unknown opcode in DECODE -> HALT with illegal_o=1 (sticky until reset).
- Undefined: unknown opcode -> FETCH (executes as NOP, PC already advanced). illegal_o is tied to 0.

Decomposition:
- Package cpu_ctrl_pkg: opcode constants, ALUOp encodings (shared with ALU_Ctrl), state encoding, pc_src/alu_src_b encodings.
- One sub-module, mc_out_dec: combinational state+opcode -> control-vector decode. The FSM and counter stay in multi_cycle_ctrl.

Test Plan:
- add (op 000000), mem_ready_i tied 1 -> states FETCH, DECODE, EXEC, WB; reg_we_o=1 and reg_dst_o=1 only in cycle 4; ALUOp_o=0 in EXEC.
- lw with mem_ready_i low 3 cycles in MEMRD -> 8 cycles total; mem_to_reg_o=1 in MEMWB; no bus_err_o.
- beq with zero_i=1 -> pc_we_o=1 and pc_src_o=1 in BRANCH. bne with zero_i=1 -> pc_we_o=0. Both return to FETCH.
- TIMEOUT=15, mem_ready_i stuck 0 in FETCH -> bus_err_o=1 after 15 wait cycles, state HALT; rst_i=0 one edge -> FETCH, bus_err_o=0.
- Opcode 111111 -> with MC_ILLEGAL_TRAP_EN: HALT, illegal_o=1. Without: back to FETCH after DECODE, no strobes.
- rst_i=0 asserted in MEMWR -> next edge state FETCH, mem_wr_o=0.
